avr_uart_tx: RTL and testbench
==============================

# avr_uart_tx

FPGA-to-AVR serial transmitter. It sends one byte at a time on the `avr_rx` line as 8N1 UART, LSB first, with 1 start bit and 1 stop bit. It honours the AVR's `avr_rx_busy` flow-control input. It sits between any byte-producing logic in the top level and the AVR serial pins, and is the transmit counterpart to the AVR→FPGA receive path on `avr_tx`.

## Interface
Parameters:
- `CLK_PER_BIT`, default 100: clock cycles per UART bit (50 MHz / 500 kbaud). Must be ≥ 2.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock (50 MHz).
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `data`, in, 8: byte to send. Sampled only on accept.
- `new_data`, in, 1: valid. Byte offered this cycle.
- `ready`, out, 1: block can accept. Accept happens when `new_data && ready` at a rising edge.
- `block`, in, 1: connects to `avr_rx_busy`. Asynchronous to the block; high means the AVR buffer is full.
- `tx`, out, 1: serial line to `avr_rx`. Idle high.

## Operation
- **Input sync:** `block` passes through a 2-flop synchronizer. The synchronized value `block_s` resets to 1.
- **States:** IDLE, START, DATA, (PARITY), STOP.
- **IDLE:**
  - `tx`=1.
  - `ready` = (state==IDLE) && !`block_s`. It is decoded combinationally from registers.
  - On accept: latch `data` into the shift register, clear the bit counter and cycle counter, go to START.
- **START:** `tx`=0 for `CLK_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx`=shreg[0] for `CLK_PER_BIT` cycles per bit, then shift right.
  - After bit index 7 completes, go to PARITY if enabled, else STOP.
- **STOP:** `tx`=1 for `CLK_PER_BIT` cycles, then go to IDLE.
- **Counters:**
  - Cycle counter width is $clog2(`CLK_PER_BIT`). It wraps to 0 on reaching `CLK_PER_BIT`-1.
  - Bit index is 3 bits. It is advanced only on a cycle-counter wrap.
- **`new_data` while `ready`=0:** ignored, no queuing.
- **`data` changes after accept:** no effect on the frame in flight.
- **`block` rising mid-frame:** the current frame completes unchanged. Only the next accept is inhibited.
- **Reset mid-frame:** the frame is abandoned and the byte is lost.

## Timing
- **Reset values:**
  - `tx`=1 and `ready`=0 (state IDLE, `block_s`=1), applied asynchronously.
  - `ready` first rises on the 2nd rising edge after `rst_n` deasserts, if `block` is low.
- **`tx` is registered:** the start bit appears on `tx` in the cycle after the accept edge.
- **Frame length:** exactly 10×`CLK_PER_BIT` cycles of `tx` activity (11× with parity).
- **`ready` low** from the cycle after accept until the cycle after the last stop-bit cycle.
- **Back-to-back throughput:** with `new_data` held high, the next start bit begins 10×`CLK_PER_BIT`+1 cycles after the previous one. The stop bit is effectively `CLK_PER_BIT`+1 cycles long.
- **`block` latency:** a change on `block` affects `ready` 2 cycles later.

## Configuration
- `AVR_UART_TX_PARITY_EN`:
  - Defined: the PARITY state inserts one even-parity bit (XOR of the 8 data bits) between bit 7 and stop, for `CLK_PER_BIT` cycles. Frame is 11 bits.
  - Undefined: PARITY state and logic are absent. Frame is 10 bits (8N1).

## Structure
- **Shared package `avr_uart_pkg`:**
  - State encoding constants.
  - Default `CLK_PER_BIT`.
  - Frame-length constants.
  - Reused later by a matching receiver.
- **Sub-module `sync_2ff`:** 1-bit, async active-low reset with a parameterised reset value. Used for `block`.

## Test plan
Directed scenarios, with `CLK_PER_BIT`=4 unless noted:
- **Single byte:** `block`=0, reset, accept 0xA5 → `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; `ready` low for 40 cycles; then `tx` idles at 1.
- **Back-to-back:** `new_data` held high with 0x00 then 0xFF → start bits 41 cycles apart; the second frame's data bits are all 1.
- **Blocked before send:** `block`=1, offer 0x3C → `ready` stays 0 and `tx` stays 1. Drop `block` → `ready` rises 2 cycles later, and 0x3C is sent.
- **Blocked mid-frame:** raise `block` during bit 3 → the frame completes intact; `ready` stays 0 after the stop bit until `block` is dropped.
- **Reset mid-frame:** assert `rst_n` low during DATA → `tx`=1 and `ready`=0 immediately. After release, the next byte is transmitted correctly.
- **Parity:** with `AVR_UART_TX_PARITY_EN`, send 0x07 → the parity bit is 1; the frame lasts 44 cycles.

Source files
------------

// File: rtl/avr_uart_pkg.sv
// -----------------------------------------------------------------------------
// avr_uart_pkg
// Shared definitions for the FPGA <-> AVR serial link (transmitter now, a
// matching receiver later): FSM state encoding, default bit timing and frame
// geometry, plus an even-parity helper.
// -----------------------------------------------------------------------------
package avr_uart_pkg;

  // 50 MHz system clock / 500 kbaud
  localparam int DEFAULT_CLK_PER_BIT = 100;

  // Frame geometry
  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  // Serial FSM state encoding (PARITY only reachable when parity is built in)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: XOR of all data bits, so data plus parity has an even count of ones
  function automatic logic even_parity(input logic [7:0] byte_i);
    return ^byte_i;
  endfunction

endpackage : avr_uart_pkg

// File: rtl/avr_uart_tx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; both flops load RST_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (two clock cycles of latency)
// Parameter:
//   RST_VAL - value both stages take during reset
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/avr_uart_tx.sv
// -----------------------------------------------------------------------------
// avr_uart_tx
// FPGA -> AVR serial transmitter. Sends one byte per frame on the AVR's
// receive pin as UART, LSB first, one start bit and one stop bit, and holds
// off new bytes while the AVR signals that its buffer is full.
//
// Optional feature macro: AVR_UART_TX_PARITY_EN
//   defined   -> one even-parity bit between data bit 7 and stop (8E1)
//   undefined -> plain 8N1, no parity state or logic
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   data     - byte to send, captured only on accept
//   new_data - byte offered this cycle
//   ready    - block can accept; accept = new_data && ready at a rising edge
//   block    - avr_rx_busy from the AVR, asynchronous; high = AVR full
//   tx       - serial line to avr_rx, idles high
// Parameter:
//   CLK_PER_BIT - clock cycles per UART bit, must be >= 2
// -----------------------------------------------------------------------------
module avr_uart_tx
  import avr_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       ready,
  input  logic       block,
  output logic       tx
);

  localparam int            CW       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CTR_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] ctr_q,   ctr_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q,    tx_d;
`ifdef AVR_UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic block_s;
  logic accept_s;
  logic wrap_s;

  // block starts out asserted so nothing is accepted until the AVR is seen idle
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_block_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (block),
    .q_o   (block_s)
  );

  assign ready    = (state_q == ST_IDLE) && !block_s;
  assign accept_s = new_data && ready;
  assign wrap_s   = (ctr_q == CTR_LAST);
  assign tx       = tx_q;

  // Next-state logic: frame sequencing, bit timing and data shifting
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
`ifdef AVR_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          shreg_d  = data;
          ctr_d    = '0;
          bit_d    = 3'd0;
`ifdef AVR_UART_TX_PARITY_EN
          parity_d = even_parity(data);
`endif
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        if (wrap_s) begin
          ctr_d   = '0;
          state_d = ST_DATA;
        end else begin
          ctr_d   = ctr_q + CW'(1'b1);
        end
      end
      ST_DATA: begin
        if (wrap_s) begin
          ctr_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
`ifdef AVR_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          ctr_d   = ctr_q + CW'(1'b1);
        end
      end
`ifdef AVR_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (wrap_s) begin
          ctr_d   = '0;
          state_d = ST_STOP;
        end else begin
          ctr_d   = ctr_q + CW'(1'b1);
        end
      end
`endif
      ST_STOP: begin
        if (wrap_s) begin
          ctr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ctr_d   = ctr_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ctr_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Line level decoded from the next state so tx changes on the same edge as the state
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef AVR_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and registered line output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      bit_q    <= 3'd0;
      shreg_q  <= 8'h00;
      tx_q     <= 1'b1;
`ifdef AVR_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
`ifdef AVR_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule : avr_uart_tx

// File: tb/tb_avr_uart_tx.sv
module tb_avr_uart_tx;

  localparam int CPB = 4;
`ifdef AVR_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       new_data;
  logic       ready;
  logic       block;
  logic       tx;

  int vectors    = 0;
  int miscompares = 0;

  avr_uart_tx #(
    .CLK_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .new_data (new_data),
    .ready    (ready),
    .block    (block),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as seen on the line, index 0 = start bit
  function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef AVR_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // Called just after the accept edge; checks every cycle of the frame and
  // returns positioned on the first cycle after the last stop-bit cycle.
  task automatic expect_frame(input string name, input logic [10:0] frame, input int block_at);
    for (int i = 0; i < NBITS * CPB; i++) begin
      if (i == block_at) block = 1'b1;
      vectors++;
      if (tx !== frame[i / CPB]) begin
        miscompares++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, i, tx, frame[i / CPB]);
      end
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ready cycle %0d: got %b expected 0", name, i, ready);
      end
      tick();
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s wait_ready: got %b expected 1 within 20 cycles", name, ready);
    end
  endtask

  task automatic check_idle(input string name, input logic exp_ready);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle tx: got %b expected 1", name, tx);
    end
    vectors++;
    if (ready !== exp_ready) begin
      miscompares++;
      $display("FAIL %s idle ready: got %b expected %b", name, ready, exp_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; block = 1'b0; new_data = 1'b0; data = 8'h00;
    #12;
    check_idle("reset_held", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_idle("reset_edge1", 1'b0);
    tick();
    check_idle("reset_edge2", 1'b1);
  endtask

  task automatic test_single_byte();
    logic [10:0] f;
`ifdef AVR_UART_TX_PARITY_EN
    f = 11'b1_0_1010_0101_0;
`else
    f = 11'b1_1_1010_0101_0;
`endif
    wait_ready("single");
    data = 8'hA5; new_data = 1'b1;
    tick();
    new_data = 1'b0; data = 8'h00;
    expect_frame("single_A5", f, -1);
    check_idle("single_end", 1'b1);
    tick();
    check_idle("single_after", 1'b1);
  endtask

  task automatic test_back_to_back();
    wait_ready("b2b");
    data = 8'h00; new_data = 1'b1;
    tick();
    data = 8'hFF;
    expect_frame("b2b_first", mk_frame(8'h00), -1);
    check_idle("b2b_gap", 1'b1);
    tick();
    new_data = 1'b0;
    expect_frame("b2b_second", mk_frame(8'hFF), -1);
    check_idle("b2b_end", 1'b1);
  endtask

  task automatic test_blocked_before();
    tick();
    block = 1'b1;
    tick();
    tick();
    data = 8'h3C; new_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_idle("blocked_hold", 1'b0);
      tick();
    end
    block = 1'b0;
    tick();
    check_idle("unblock_edge1", 1'b0);
    tick();
    check_idle("unblock_edge2", 1'b1);
    tick();
    new_data = 1'b0;
    expect_frame("blocked_3C", mk_frame(8'h3C), -1);
    check_idle("blocked_end", 1'b1);
  endtask

  task automatic test_block_midframe();
    wait_ready("midblock");
    data = 8'h5A; new_data = 1'b1;
    tick();
    new_data = 1'b0;
    expect_frame("midblock_5A", mk_frame(8'h5A), 4 + 3 * CPB);
    for (int i = 0; i < 5; i++) begin
      check_idle("midblock_hold", 1'b0);
      tick();
    end
    block = 1'b0;
    tick();
    check_idle("midblock_rel1", 1'b0);
    tick();
    check_idle("midblock_rel2", 1'b1);
  endtask

  task automatic test_reset_midframe();
    wait_ready("rstmid");
    data = 8'h81; new_data = 1'b1;
    tick();
    new_data = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check_idle("rstmid_async", 1'b0);
    tick();
    check_idle("rstmid_held", 1'b0);
    rst_n = 1'b1;
    tick();
    check_idle("rstmid_rel1", 1'b0);
    tick();
    check_idle("rstmid_rel2", 1'b1);
    data = 8'h42; new_data = 1'b1;
    tick();
    new_data = 1'b0;
    expect_frame("rstmid_42", mk_frame(8'h42), -1);
    check_idle("rstmid_end", 1'b1);
  endtask

`ifdef AVR_UART_TX_PARITY_EN
  task automatic test_parity();
    wait_ready("parity");
    data = 8'h07; new_data = 1'b1;
    tick();
    new_data = 1'b0;
    expect_frame("parity_07", 11'b1_1_0000_0111_0, -1);
    check_idle("parity_end", 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_blocked_before();
    test_block_midframe();
    test_reset_midframe();
`ifdef AVR_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_avr_uart_tx
